// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM state encoding and
// the canonical stage indices used by the CNN top level.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ADV   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Stage indices of the reference CNN pipeline
  localparam int STG_CONV1   = 0;
  localparam int STG_RELU1   = 1;
  localparam int STG_POOL1   = 2;
  localparam int STG_CONV2   = 3;
  localparam int STG_RELU2   = 4;
  localparam int STG_FLATTEN = 5;
  localparam int STG_DENSE   = 6;
  localparam int STG_ARGMAX  = 7;
  localparam int NUM_CNN_STAGES = STG_ARGMAX + 1;

endpackage

// File: rtl/cnn_seq_watchdog.sv
// Per-stage watchdog: counts cycles spent waiting on a stage and flags
// expiry on the last allowed WAIT cycle so the FSM can force an advance.
module cnn_seq_watchdog #(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int W = $clog2(WDOG_CYCLES + 1);

  logic [W-1:0] r_cnt;

  // Counter clears on each stage issue and counts WAIT cycles, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_inc && (r_cnt == W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: walks NUM_STAGES layer engines with a start/done
// handshake, one frame at a time, with per-frame stage skipping, abort and
// a saturating frame cycle count.
// Optional per-stage watchdog enabled by defining SEQ_WATCHDOG_EN.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 8,
  parameter int STG_W       = 5,
  parameter int CNT_W       = 24,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [NUM_STAGES-1:0] skip_mask,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [STG_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [CNT_W-1:0]      frame_cycles,
  output logic                  proto_err,
  output logic                  timeout_err
);

  seq_state_t            r_state;
  logic [STG_W-1:0]      r_cur;
  logic [NUM_STAGES-1:0] r_skip;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_proto;

  logic [NUM_STAGES-1:0] w_cur_oh;
  logic                  w_cur_skip;
  logic                  w_done_cur;
  logic                  w_done_other;
  logic                  w_last;
  logic                  w_expire;
  logic                  w_in_frame;

  assign w_cur_oh     = NUM_STAGES'(1) << r_cur;
  assign w_cur_skip   = |(r_skip & w_cur_oh);
  assign w_done_cur   = |(stage_done & w_cur_oh);
  assign w_done_other = |(stage_done & ~w_cur_oh);
  assign w_last       = (r_cur == STG_W'(NUM_STAGES - 1));
  assign w_in_frame   = (r_state != ST_IDLE) && (r_state != ST_DONE);

  // Start pulse is decoded from ISSUE so an abort in that cycle suppresses it
  assign stage_start = (r_state == ST_ISSUE && !w_cur_skip && !abort) ? w_cur_oh : '0;

`ifdef SEQ_WATCHDOG_EN
  logic r_tmo;

  cnn_seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state == ST_ISSUE),
    .i_inc    (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= 1'b0;
    end else if (w_expire && !abort) begin
      r_tmo <= 1'b1;
    end
  end

  assign timeout_err = r_tmo;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Sticky protocol error: a done from any stage other than the current one,
  // or any done while no frame is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proto <= 1'b0;
    end else if ((w_in_frame && w_done_other) || (!w_in_frame && |stage_done)) begin
      r_proto <= 1'b1;
    end
  end

  // Main sequencing FSM with frame cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_skip  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_in_frame && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_IDLE) begin
        if (frame_valid) begin
          r_skip  <= skip_mask;
          r_cnt   <= '0;
          r_cur   <= '0;
          r_state <= ST_ISSUE;
        end
      end else if (abort) begin
        r_cur   <= '0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_ISSUE: r_state <= w_cur_skip ? ST_ADV : ST_WAIT;
          ST_WAIT: begin
            if (w_done_cur || w_expire) r_state <= ST_ADV;
          end
          ST_ADV: begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_cur   <= r_cur + 1'b1;
              r_state <= ST_ISSUE;
            end
          end
          ST_DONE: begin
            if (result_ready) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign frame_ready  = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign result_valid = (r_state == ST_DONE);
  assign cur_stage    = r_cur;
  assign frame_cycles = r_cnt;
  assign proto_err    = r_proto;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: a stimulus process runs frames
// and stage responders, a reference model predicts start pulses and results,
// and a negedge monitor compares whatever the DUT presents.
module tb_cnn_layer_sequencer;

  localparam int NS  = 8;
  localparam int SW  = 5;
  localparam int CW  = 6;
  localparam int WD  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [NS-1:0] skip_mask = '0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic [SW-1:0] cur_stage;
  logic          busy;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [CW-1:0] frame_cycles;
  logic          proto_err;
  logic          timeout_err;

  cnn_layer_sequencer #(
    .NUM_STAGES (NS), .STG_W (SW), .CNT_W (CW), .WDOG_CYCLES (WD)
  ) dut (
    .clk (clk), .rst (rst),
    .frame_valid (frame_valid), .frame_ready (frame_ready),
    .skip_mask (skip_mask), .abort (abort),
    .stage_start (stage_start), .stage_done (stage_done),
    .cur_stage (cur_stage), .busy (busy),
    .result_valid (result_valid), .result_ready (result_ready),
    .frame_cycles (frame_cycles),
    .proto_err (proto_err), .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int stg; int cyc; } st_exp_t;
  typedef struct { int cyc; int fc; }  res_exp_t;
  st_exp_t  sq[$];
  res_exp_t rq[$];

  // Reference model: ISSUE+ADV for a skipped stage, ISSUE + lat WAIT cycles
  // + ADV for an active one; DONE follows the last stage.
  task automatic model(input int t, input logic [NS-1:0] m, input int lat[NS],
                       output int st[NS], output int dcyc, output int fc);
    int c;
    c = t + 1;
    for (int k = 0; k < NS; k++) begin
      if (m[k]) begin
        st[k] = -1;
        c += 2;
      end else begin
        st[k] = c;
        c += lat[k] + 2;
      end
    end
    dcyc = c;
    fc   = (c - t - 1 > SAT) ? SAT : c - t - 1;
  endtask

  int   cur_lat[NS];
  int   pend_stg = -1;
  int   pend_cyc = 0;
  logic exp_proto = 1'b0;

  // One clock: drive this cycle's done pulse, then note any start pulse
  task automatic tick();
    @(posedge clk);
    #1;
    abort      = 1'b0;
    stage_done = '0;
    if (pend_stg >= 0 && cyc == pend_cyc) begin
      stage_done = NS'(1) << pend_stg;
      pend_stg   = -1;
    end
    #1;
    for (int i = 0; i < NS; i++)
      if (stage_start[i]) begin
        pend_stg = i;
        pend_cyc = cyc + cur_lat[i];
      end
  endtask

  task automatic run_frame(input logic [NS-1:0] m, input int lat[NS], input int rdy_dly,
                           input bit hold_fv, input int abort_stg, input int proto_stg);
    int st[NS];
    int dc, fc, t, k;
    cur_lat     = lat;
    skip_mask   = m;
    frame_valid = 1'b1;
    k = 0;
    while (!frame_ready && k < 100) begin tick(); k++; end
    chk("frame_accepted", frame_ready, 1);
    t = cyc;
    model(t, m, lat, st, dc, fc);
    for (int i = 0; i < NS; i++)
      if (st[i] >= 0 && (abort_stg < 0 || i <= abort_stg)) sq.push_back('{i, st[i]});
    if (abort_stg < 0) rq.push_back('{dc, fc});
    tick();
    skip_mask   = NS'($urandom);
    frame_valid = hold_fv;
    chk("busy_after_accept", busy, 1);
    if (abort_stg >= 0) begin
      while (cyc < st[abort_stg] + 1) tick();
      abort    = 1'b1;
      pend_stg = -1;
      tick();
      chk("abort_frame_ready", frame_ready, 1);
      chk("abort_busy", busy, 0);
      repeat (6) tick();
      return;
    end
    if (proto_stg >= 0) begin
      while (cyc < st[proto_stg] + 2) tick();
      stage_done = stage_done | (NS'(1) << ((proto_stg + 3) % NS));
      exp_proto  = 1'b1;
      tick();
      chk("proto_set", proto_err, 1);
    end
    k = 0;
    while (!result_valid && k < 3000) begin tick(); k++; end
    chk("result_seen", result_valid, 1);
    repeat (rdy_dly) tick();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    frame_valid  = 1'b0;
    chk("ready_after_handshake", frame_ready, 1);
    chk("proto_flag", proto_err, exp_proto);
  endtask

  // Monitor: compare start pulses and results against the scoreboard
  st_exp_t  me;
  res_exp_t mr;
  int       midx;
  int       mfc = 0;
  logic     rv_q = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (|stage_start) begin
        chk("start_onehot", $onehot(stage_start), 1);
        if (sq.size() == 0) begin
          chk("unexpected_start", stage_start, 0);
        end else begin
          me   = sq.pop_front();
          midx = -1;
          for (int i = 0; i < NS; i++) if (stage_start[i]) midx = i;
          chk("start_stage", midx, me.stg);
          chk("start_cycle", cyc, me.cyc);
          chk("cur_stage", cur_stage, me.stg);
        end
      end
      if (result_valid) begin
        chk("no_accept_in_done", frame_ready, 0);
        if (!rv_q) begin
          if (rq.size() == 0) begin
            chk("unexpected_result", result_valid, 0);
          end else begin
            mr  = rq.pop_front();
            mfc = mr.fc;
            chk("result_cycle", cyc, mr.cyc);
            chk("frame_cycles", frame_cycles, mr.fc);
`ifndef SEQ_WATCHDOG_EN
            chk("timeout_tied_low", timeout_err, 0);
`endif
          end
        end else begin
          chk("frame_cycles_stable", frame_cycles, mfc);
        end
      end
      rv_q <= result_valid && !result_ready;
    end
  end

  int lat3[NS], latp[NS], lat4[NS], lat8[NS], latr[NS];

  initial begin
    for (int i = 0; i < NS; i++) begin
      lat3[i] = 3; latp[i] = 3; lat4[i] = 4; lat8[i] = 8;
    end
    latp[2] = 6;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_stage_start", stage_start, 0);
    chk("rst_cur_stage", cur_stage, 0);
    chk("rst_frame_cycles", frame_cycles, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (2) tick();

    run_frame(8'h00, lat3, 2, 1'b0, -1, -1);   // all stages, 5 cycles each
    run_frame(8'h06, lat3, 0, 1'b0, -1, -1);   // stages 1,2 bypassed
    run_frame(8'hFF, lat3, 10, 1'b1, -1, -1);  // all bypassed, consumer stalls
    run_frame(8'h00, lat8, 1, 1'b0, -1, -1);   // counter saturates
    run_frame(8'h00, latp, 1, 1'b0, -1, 2);    // stray done while on stage 2
    run_frame(8'h00, lat4, 0, 1'b0, 4, -1);    // abort while waiting on stage 4
    run_frame(8'h81, lat3, 0, 1'b0, -1, -1);   // normal frame after abort

    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NS; i++) latr[i] = $urandom_range(1, 6);
      run_frame(NS'($urandom), latr, $urandom_range(0, 4), 1'b0, -1, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    chk("start_queue_drained", sq.size(), 0);
    chk("result_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
